// File: rtl/iob_cache_fe_pipe_pkg.sv
// Shared widths and response encoding for the cache front-end pipe.
// Word-address and packed queue-entry widths derive from the byte geometry.
package iob_cache_fe_pipe_pkg;

  function automatic int fe_word_addr_w(input int addr_w, input int data_w);
    return addr_w - $clog2(data_w / 8);
  endfunction

  function automatic int fe_entry_w(input int addr_w, input int data_w);
    return fe_word_addr_w(addr_w, data_w) + data_w + data_w / 8;
  endfunction

  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_READ,
    RSP_WRITE
  } rsp_e;

endpackage

// File: rtl/iob_fe_req_fifo.sv
// Request queue: register array with wrapping pointers and a level count.
// The head entry is read combinationally so it can drive the cache port.
module iob_fe_req_fifo #(
  parameter int ENTRY_W = 8,
  parameter int DEPTH_W = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] head,
  output logic [DEPTH_W:0]   level
);

  localparam int DEPTH = 2 ** DEPTH_W;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr;
  logic [DEPTH_W-1:0] rd_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr] <= din;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
    end
  end

  assign head = mem_q[rd_ptr];

endmodule

// File: rtl/iob_cache_fe_pipe.sv
// CPU-to-cache request pipe: queues requests, replays the head until ready,
// and returns a registered one-cycle read/write completion.
module iob_cache_fe_pipe
  import iob_cache_fe_pipe_pkg::*;
#(
  parameter int FE_ADDR_W = 32,
  parameter int FE_DATA_W = 32,
  parameter int DEPTH_W   = 1,
  parameter int BUBBLE    = 0,
  localparam int WA_W     = fe_word_addr_w(FE_ADDR_W, FE_DATA_W),
  localparam int SW       = FE_DATA_W / 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cpu_valid,
  input  logic [WA_W-1:0]      cpu_addr,
  input  logic [FE_DATA_W-1:0] cpu_wdata,
  input  logic [SW-1:0]        cpu_wstrb,
  output logic                 cpu_ack,
  output logic                 cpu_rvalid,
  output logic                 cpu_wdone,
  output logic [FE_DATA_W-1:0] cpu_rdata,
  output logic                 valid,
  output logic [WA_W-1:0]      addr,
  output logic [FE_DATA_W-1:0] wdata,
  output logic [SW-1:0]        wstrb,
  input  logic [FE_DATA_W-1:0] rdata,
  input  logic                 ready,
  output logic [DEPTH_W:0]     level,
  output logic                 proto_err
);

  localparam int ENTRY_W = fe_entry_w(FE_ADDR_W, FE_DATA_W);
  localparam logic [DEPTH_W:0] FULL = (DEPTH_W + 1)'(2 ** DEPTH_W);

  logic               push;
  logic               pop;
  logic               bubble;
  logic [ENTRY_W-1:0] head;
  rsp_e               rsp_q;
  rsp_e               rsp_d;

  // ack depends only on the registered level, never on ready
  assign cpu_ack = (level != FULL);
  assign push    = cpu_valid & cpu_ack;
  assign valid   = (level != '0) & ~bubble;
  assign pop     = valid & ready;

  iob_fe_req_fifo #(
    .ENTRY_W (ENTRY_W),
    .DEPTH_W (DEPTH_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     ({cpu_addr, cpu_wdata, cpu_wstrb}),
    .head    (head),
    .level   (level)
  );

  assign {addr, wdata, wstrb} = head;

  if (BUBBLE != 0) begin : g_bubble
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        bubble <= 1'b0;
      end else begin
        bubble <= pop;
      end
    end
  end else begin : g_no_bubble
    assign bubble = 1'b0;
  end

  always_comb begin
    rsp_d = RSP_NONE;
    unique case (1'b1)
      pop & ~|wstrb: rsp_d = RSP_READ;
      pop & |wstrb:  rsp_d = RSP_WRITE;
      default:       rsp_d = RSP_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_q     <= RSP_NONE;
      cpu_rdata <= '0;
      proto_err <= 1'b0;
    end else begin
      rsp_q <= rsp_d;
      if (rsp_d == RSP_READ) begin
        cpu_rdata <= rdata;
      end
      // stray ready is flagged but otherwise has no effect
      if (ready && !valid) begin
        proto_err <= 1'b1;
      end
    end
  end

  assign cpu_rvalid = (rsp_q == RSP_READ);
  assign cpu_wdone  = (rsp_q == RSP_WRITE);

endmodule

// File: tb/tb_iob_cache_fe_pipe.sv
// Scoreboard bench for iob_cache_fe_pipe: directed requests, a small cache
// model, and monitors that pop expected requests/responses from queues.
module tb_iob_cache_fe_pipe;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } req_t;

  typedef struct {
    bit          rd;
    logic [31:0] d;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        cpu_valid, cpu_ack, cpu_rvalid, cpu_wdone;
  logic [29:0] cpu_addr, addr;
  logic [31:0] cpu_wdata, cpu_rdata, wdata, rdata;
  logic [3:0]  cpu_wstrb, wstrb;
  logic        valid, ready, proto_err;
  logic [1:0]  level;

  logic        b_cpu_valid, b_cpu_ack, b_cpu_rvalid, b_cpu_wdone;
  logic [29:0] b_cpu_addr, b_addr;
  logic [31:0] b_cpu_wdata, b_cpu_rdata, b_wdata, b_rdata;
  logic [3:0]  b_cpu_wstrb, b_wstrb;
  logic        b_valid, b_ready, b_proto_err;
  logic [1:0]  b_level;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int b_resp_n = 0;

  req_t exp_req0[$], exp_req1[$];
  rsp_t exp_rsp0[$], exp_rsp1[$];
  int   resp_cyc0[$];
  bit   bvq[$];
  bit   rec_on = 1'b0;

  logic [31:0] mem [16];
  logic        mem_ok = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  iob_cache_fe_pipe #(
    .FE_ADDR_W(32), .FE_DATA_W(32), .DEPTH_W(1), .BUBBLE(0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid),
    .cpu_wdone(cpu_wdone), .cpu_rdata(cpu_rdata),
    .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready), .level(level), .proto_err(proto_err)
  );

  iob_cache_fe_pipe #(
    .FE_ADDR_W(32), .FE_DATA_W(32), .DEPTH_W(1), .BUBBLE(1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n),
    .cpu_valid(b_cpu_valid), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_wstrb(b_cpu_wstrb), .cpu_ack(b_cpu_ack), .cpu_rvalid(b_cpu_rvalid),
    .cpu_wdone(b_cpu_wdone), .cpu_rdata(b_cpu_rdata),
    .valid(b_valid), .addr(b_addr), .wdata(b_wdata), .wstrb(b_wstrb),
    .rdata(b_rdata), .ready(b_ready), .level(b_level), .proto_err(b_proto_err)
  );

  // cache model: combinational read, byte-masked write on completion
  assign rdata   = mem[addr[3:0]];
  assign b_rdata = mem[b_addr[3:0]];

  always @(posedge clk) begin
    if (!mem_ok) begin
      for (int i = 0; i < 16; i++)
        mem[i] <= (i == 3) ? 32'hA5 : 32'h100 + i;
      mem_ok <= 1'b1;
    end else if (valid && ready && wstrb != 4'h0) begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) mem[addr[3:0]][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // request-side monitors: head presented at completion must match order
  req_t q0, q1;
  always @(negedge clk) begin
    #2;
    if (valid && ready) begin
      if (exp_req0.size() == 0) chk("req0_unexpected", 1, 0);
      else begin
        q0 = exp_req0.pop_front();
        chk("req0_addr", addr, q0.a);
        chk("req0_wdata", wdata, q0.d);
        chk("req0_wstrb", wstrb, q0.s);
      end
    end
    if (b_valid && b_ready) begin
      if (exp_req1.size() == 0) chk("req1_unexpected", 1, 0);
      else begin
        q1 = exp_req1.pop_front();
        chk("req1_addr", b_addr, q1.a);
      end
    end
  end

  // response-side monitors
  rsp_t e0, e1;
  always @(negedge clk) begin
    if (cpu_rvalid || cpu_wdone) begin
      resp_cyc0.push_back(cyc);
      if (exp_rsp0.size() == 0) chk("rsp0_unexpected", {cpu_rvalid, cpu_wdone}, 0);
      else begin
        e0 = exp_rsp0.pop_front();
        chk("rsp0_kind", {cpu_rvalid, cpu_wdone}, e0.rd ? 2'b10 : 2'b01);
        if (e0.rd) chk("rsp0_rdata", cpu_rdata, e0.d);
      end
    end
    if (b_cpu_rvalid || b_cpu_wdone) begin
      b_resp_n++;
      if (exp_rsp1.size() == 0) chk("rsp1_unexpected", 1, 0);
      else begin
        e1 = exp_rsp1.pop_front();
        chk("rsp1_kind", {b_cpu_rvalid, b_cpu_wdone}, e1.rd ? 2'b10 : 2'b01);
        if (e1.rd) chk("rsp1_rdata", b_cpu_rdata, e1.d);
      end
    end
  end

  always @(negedge clk) if (rec_on) bvq.push_back(b_valid);

  // called at a negedge; returns on the edge where the request is accepted
  task automatic push(input bit which, input logic [29:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] exp);
    int n;
    req_t r;
    rsp_t e;
    r = '{a: a, d: d, s: s};
    e = '{rd: (s == 4'h0), d: exp};
    if (!which) begin
      cpu_valid = 1'b1; cpu_addr = a; cpu_wdata = d; cpu_wstrb = s;
    end else begin
      b_cpu_valid = 1'b1; b_cpu_addr = a; b_cpu_wdata = d; b_cpu_wstrb = s;
    end
    n = 0;
    while (!(which ? b_cpu_ack : cpu_ack) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("push_ack_timeout", 0, 1);
    @(posedge clk);
    if (!which) begin
      exp_req0.push_back(r);
      exp_rsp0.push_back(e);
    end else begin
      exp_req1.push_back(r);
      exp_rsp1.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] pat;
    int first;

    reset_n = 1'b0;
    cpu_valid = 0; cpu_addr = 0; cpu_wdata = 0; cpu_wstrb = 0; ready = 0;
    b_cpu_valid = 0; b_cpu_addr = 0; b_cpu_wdata = 0; b_cpu_wstrb = 0;
    b_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_level", level, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ack", cpu_ack, 1);
    chk("rst_rvalid", cpu_rvalid, 0);
    chk("rst_wdone", cpu_wdone, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_proto_err", proto_err, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // T1: single read, ready one cycle after valid
    push(0, 30'd3, 0, 4'h0, 32'hA5);
    @(negedge clk);
    cpu_valid = 0;
    chk("t1_valid_latency", valid, 1);
    chk("t1_addr", addr, 3);
    chk("t1_level", level, 1);
    @(negedge clk);
    chk("t1_addr_stable", addr, 3);
    chk("t1_valid_hold", valid, 1);
    ready = 1;
    @(negedge clk);
    ready = 0;
    chk("t1_level_after", level, 0);
    @(negedge clk);
    chk("t1_rvalid_pulse", cpu_rvalid, 0);

    // T2: burst of 9 writes, one completion per cycle
    resp_cyc0.delete();
    push(0, 30'd1, 32'd1, 4'hF, 0);
    for (int i = 2; i <= 9; i++) begin
      @(negedge clk);
      ready = 1;
      push(0, 30'(i), 32'(i), 4'hF, 0);
    end
    @(negedge clk);
    cpu_valid = 0;
    @(negedge clk);
    ready = 0;
    repeat (2) @(negedge clk);
    chk("t2_wdone_count", resp_cyc0.size(), 9);
    if (resp_cyc0.size() == 9)
      chk("t2_consecutive", resp_cyc0[8] - resp_cyc0[0], 8);
    for (int i = 1; i <= 9; i++) chk("t2_mem", mem[i], i);

    // T3: fill with ready low, then drain
    push(0, 30'd10, 0, 4'h0, 32'h10A);
    @(negedge clk);
    push(0, 30'd11, 0, 4'h0, 32'h10B);
    @(negedge clk);
    cpu_addr = 30'd12;
    chk("t3_ack_full", cpu_ack, 0);
    chk("t3_level_full", level, 2);
    chk("t3_head", addr, 10);
    @(negedge clk);
    cpu_valid = 0;
    chk("t3_level_hold", level, 2);
    chk("t3_head_hold", addr, 10);
    ready = 1;
    n = 0;
    while (level != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ready = 0;
    chk("t3_drain", level, 0);
    @(negedge clk);
    chk("t3_rsp_empty", exp_rsp0.size(), 0);

    // T4: simultaneous push and pop at level 1
    push(0, 30'd12, 0, 4'h0, 32'h10C);
    @(negedge clk);
    ready = 1;
    push(0, 30'd13, 0, 4'h0, 32'h10D);
    @(negedge clk);
    ready = 0;
    cpu_valid = 0;
    chk("t4_level", level, 1);
    chk("t4_new_head", addr, 13);
    chk("t4_valid", valid, 1);
    ready = 1;
    @(negedge clk);
    ready = 0;
    @(negedge clk);
    chk("t4_level_end", level, 0);
    chk("t4_rsp_empty", exp_rsp0.size(), 0);

    // T5: bubble mode, ready tied high, 4 reads
    rec_on = 1;
    b_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      push(1, 30'(i), 0, 4'h0, 32'(i));
    end
    @(negedge clk);
    b_cpu_valid = 0;
    repeat (8) @(negedge clk);
    rec_on = 0;
    b_ready = 0;
    first = -1;
    for (int i = 0; i < bvq.size(); i++)
      if (first < 0 && bvq[i]) first = i;
    pat = 8'h00;
    if (first >= 0 && first + 8 <= bvq.size())
      for (int i = 0; i < 8; i++) pat[7-i] = bvq[first+i];
    chk("t5_valid_pattern", pat, 8'b1010_1010);
    chk("t5_rvalid_count", b_resp_n, 4);
    chk("t5_rsp_empty", exp_rsp1.size(), 0);

    // T6: async reset mid-burst, then stray ready
    push(0, 30'd5, 0, 4'h0, 32'd5);
    @(negedge clk);
    push(0, 30'd6, 0, 4'h0, 32'd6);
    @(negedge clk);
    cpu_valid = 0;
    chk("t6_level_pre", level, 2);
    #3;
    reset_n = 0;
    #1;
    chk("t6_rst_level", level, 0);
    chk("t6_rst_valid", valid, 0);
    exp_req0.delete();
    exp_rsp0.delete();
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    chk("t6_proto_clear", proto_err, 0);
    ready = 1;
    @(negedge clk);
    ready = 0;
    chk("t6_proto_set", proto_err, 1);
    chk("t6_level_stray", level, 0);
    repeat (2) @(negedge clk);
    chk("t6_proto_sticky", proto_err, 1);
    chk("t6_no_rsp", cpu_rvalid, 0);
    chk("end_req0_empty", exp_req0.size(), 0);
    chk("end_req1_empty", exp_req1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
